// File: rtl/tlb_pkg.sv
// Shared TLB definitions: geometry, field widths, the entry record
// and small helpers used by the search ports.
package tlb_pkg;

   localparam int TLBNUM = 16;
   localparam int IW     = $clog2(TLBNUM);
   localparam int VPN2_W = 19;
   localparam int ASID_W = 8;
   localparam int PFN_W  = 20;
   localparam int C_W    = 3;

   typedef struct packed {
      logic [VPN2_W-1:0] vpn2;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [PFN_W-1:0]  pfn0;
      logic [C_W-1:0]    c0;
      logic              d0;
      logic              v0;
      logic [PFN_W-1:0]  pfn1;
      logic [C_W-1:0]    c1;
      logic              d1;
      logic              v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [PFN_W-1:0] pfn;
      logic [C_W-1:0]   c;
      logic             d;
      logic             v;
   } tlb_page_t;

   // An entry matches when its VPN2 agrees and it is either global or
   // tagged with the requesting ASID.
   function automatic logic key_match(input tlb_entry_t e,
                                      input logic [VPN2_W-1:0] vpn2,
                                      input logic [ASID_W-1:0] asid);
      return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
   endfunction

   // VA[12] picks the odd or even half of the entry's page pair.
   function automatic tlb_page_t select_page(input tlb_entry_t e, input logic odd_page);
      tlb_page_t p;
      if (odd_page) p = '{pfn: e.pfn1, c: e.c1, d: e.d1, v: e.v1};
      else          p = '{pfn: e.pfn0, c: e.c0, d: e.d0, v: e.v0};
      return p;
   endfunction

endpackage

// File: rtl/tlb_if.sv
// Bus between the pipeline/CP0 side (master) and the TLB (slave):
// two search ports, the TLBWI write port and the TLBR read port.
interface tlb_if;
   import tlb_pkg::*;

   logic [VPN2_W-1:0] s0_vpn2;
   logic              s0_odd_page;
   logic [ASID_W-1:0] s0_asid;
   logic              s0_found;
   logic [IW-1:0]     s0_index;
   logic [PFN_W-1:0]  s0_pfn;
   logic [C_W-1:0]    s0_c;
   logic              s0_d;
   logic              s0_v;

   logic [VPN2_W-1:0] s1_vpn2;
   logic              s1_odd_page;
   logic [ASID_W-1:0] s1_asid;
   logic              s1_found;
   logic [IW-1:0]     s1_index;
   logic [PFN_W-1:0]  s1_pfn;
   logic [C_W-1:0]    s1_c;
   logic              s1_d;
   logic              s1_v;

   logic              we;
   logic [IW-1:0]     w_index;
   logic [VPN2_W-1:0] w_vpn2;
   logic [ASID_W-1:0] w_asid;
   logic              w_g;
   logic [PFN_W-1:0]  w_pfn0;
   logic [C_W-1:0]    w_c0;
   logic              w_d0;
   logic              w_v0;
   logic [PFN_W-1:0]  w_pfn1;
   logic [C_W-1:0]    w_c1;
   logic              w_d1;
   logic              w_v1;

   logic [IW-1:0]     r_index;
   logic [VPN2_W-1:0] r_vpn2;
   logic [ASID_W-1:0] r_asid;
   logic              r_g;
   logic [PFN_W-1:0]  r_pfn0;
   logic [C_W-1:0]    r_c0;
   logic              r_d0;
   logic              r_v0;
   logic [PFN_W-1:0]  r_pfn1;
   logic [C_W-1:0]    r_c1;
   logic              r_d1;
   logic              r_v1;

   modport master (
      output s0_vpn2, s0_odd_page, s0_asid,
      input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      output s1_vpn2, s1_odd_page, s1_asid,
      input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      output we, w_index, w_vpn2, w_asid, w_g,
      output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
      output r_index,
      input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
   );

   modport slave (
      input  s0_vpn2, s0_odd_page, s0_asid,
      output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      input  s1_vpn2, s1_odd_page, s1_asid,
      output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      input  we, w_index, w_vpn2, w_asid, w_g,
      input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
      input  r_index,
      output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
   );

endinterface

// File: rtl/tlb_search_port.sv
// One combinational TLB lookup: match vector over all entries, lowest-index
// priority pick, then odd/even page select. Misses report all zeros.
module tlb_search_port
   import tlb_pkg::*;
(
   input  tlb_entry_t        entries [TLBNUM],
   input  logic [VPN2_W-1:0] vpn2,
   input  logic              odd_page,
   input  logic [ASID_W-1:0] asid,
   output logic              found,
   output logic [IW-1:0]     index,
   output logic [PFN_W-1:0]  pfn,
   output logic [C_W-1:0]    c,
   output logic              d,
   output logic              v
);

   logic [TLBNUM-1:0] match;
   tlb_page_t         hit_page;

   // Compare the key against every entry in parallel.
   always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         match[i] = key_match(entries[i], vpn2, asid);
      end
   end

   // Lowest matching index wins so duplicate entries resolve deterministically.
   always_comb begin
      found    = |match;
      index    = '0;
      hit_page = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (match[i]) index = IW'(i);
      end
      if (found) hit_page = select_page(entries[index], odd_page);
   end

   assign pfn = hit_page.pfn;
   assign c   = hit_page.c;
   assign d   = hit_page.d;
   assign v   = hit_page.v;

endmodule

// File: rtl/tlb.sv
// Fully-associative TLB: flop-based entry array with a TLBWI write port,
// a combinational TLBR read port and two independent search ports.
module tlb
   import tlb_pkg::*;
(
   input logic  clk,
   input logic  reset,
   tlb_if.slave bus
);

   tlb_entry_t entries [TLBNUM];
   tlb_entry_t rd_entry;

   // Array update: reset clears everything and overrides any write in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
      end else if (bus.we) begin
         entries[bus.w_index] <= '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
                                   pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
                                   pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};
      end
   end

   tlb_search_port u_search0 (
      .entries  (entries),
      .vpn2     (bus.s0_vpn2),
      .odd_page (bus.s0_odd_page),
      .asid     (bus.s0_asid),
      .found    (bus.s0_found),
      .index    (bus.s0_index),
      .pfn      (bus.s0_pfn),
      .c        (bus.s0_c),
      .d        (bus.s0_d),
      .v        (bus.s0_v)
   );

   tlb_search_port u_search1 (
      .entries  (entries),
      .vpn2     (bus.s1_vpn2),
      .odd_page (bus.s1_odd_page),
      .asid     (bus.s1_asid),
      .found    (bus.s1_found),
      .index    (bus.s1_index),
      .pfn      (bus.s1_pfn),
      .c        (bus.s1_c),
      .d        (bus.s1_d),
      .v        (bus.s1_v)
   );

   // TLBR reads the registered array, so a same-cycle write shows old data.
   assign rd_entry   = entries[bus.r_index];
   assign bus.r_vpn2 = rd_entry.vpn2;
   assign bus.r_asid = rd_entry.asid;
   assign bus.r_g    = rd_entry.g;
   assign bus.r_pfn0 = rd_entry.pfn0;
   assign bus.r_c0   = rd_entry.c0;
   assign bus.r_d0   = rd_entry.d0;
   assign bus.r_v0   = rd_entry.v0;
   assign bus.r_pfn1 = rd_entry.pfn1;
   assign bus.r_c1   = rd_entry.c1;
   assign bus.r_d1   = rd_entry.d1;
   assign bus.r_v1   = rd_entry.v1;

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed vector table, hand-written
// multi-cycle sequences and a randomized phase against a simple
// array-of-records reference model.
module tb_tlb;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   tlb_if bus ();

   tlb dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [18:0]      vpn2;
      logic [7:0]       asid;
      logic             g;
      logic [1:0][19:0] pfn;
      logic [1:0][2:0]  c;
      logic [1:0]       d;
      logic [1:0]       v;
   } model_entry_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic        odd;
      logic [7:0]  asid;
      logic        exp_found;
      logic [3:0]  exp_index;
      logic [19:0] exp_pfn;
      logic        exp_v;
   } vec_t;

   model_entry_t model [16];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic model_entry_t mkEntry(input logic [18:0] vpn2, input logic [7:0] asid,
                                            input logic g, input logic [19:0] pfn0,
                                            input logic [2:0] c0, input logic d0, input logic v0,
                                            input logic [19:0] pfn1, input logic [2:0] c1,
                                            input logic d1, input logic v1);
      model_entry_t e;
      e.vpn2 = vpn2; e.asid = asid; e.g = g;
      e.pfn[0] = pfn0; e.c[0] = c0; e.d[0] = d0; e.v[0] = v0;
      e.pfn[1] = pfn1; e.c[1] = c1; e.d[1] = d1; e.v[1] = v1;
      return e;
   endfunction

   // First entry (lowest index) whose VPN2 agrees and which is global or ASID-tagged.
   function automatic void modelSearch(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                                       output logic f, output logic [3:0] idx, output logic [19:0] pfn,
                                       output logic [2:0] c, output logic d, output logic v);
      f = 1'b0; idx = '0; pfn = '0; c = '0; d = 1'b0; v = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!f && model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid)) begin
            f   = 1'b1;
            idx = 4'(i);
            pfn = model[i].pfn[odd];
            c   = model[i].c[odd];
            d   = model[i].d[odd];
            v   = model[i].v[odd];
         end
      end
   endfunction

   task automatic driveWrite(input logic [3:0] idx, input model_entry_t e);
      bus.we     = 1'b1;
      bus.w_index = idx;
      bus.w_vpn2 = e.vpn2;   bus.w_asid = e.asid; bus.w_g = e.g;
      bus.w_pfn0 = e.pfn[0]; bus.w_c0 = e.c[0]; bus.w_d0 = e.d[0]; bus.w_v0 = e.v[0];
      bus.w_pfn1 = e.pfn[1]; bus.w_c1 = e.c[1]; bus.w_d1 = e.d[1]; bus.w_v1 = e.v[1];
   endtask

   // Performs one write cycle and updates the model once the edge has passed.
   task automatic applyStimulus(input logic [3:0] idx, input model_entry_t e);
      driveWrite(idx, e);
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      model[idx] = e;
   endtask

   task automatic setKeys(input logic [18:0] v0, input logic o0, input logic [7:0] a0,
                          input logic [18:0] v1, input logic o1, input logic [7:0] a1);
      bus.s0_vpn2 = v0; bus.s0_odd_page = o0; bus.s0_asid = a0;
      bus.s1_vpn2 = v1; bus.s1_odd_page = o1; bus.s1_asid = a1;
      #1;
   endtask

   task automatic checkSearches(input string tag);
      logic f; logic [3:0] idx; logic [19:0] pfn; logic [2:0] c; logic d; logic v;
      modelSearch(bus.s0_vpn2, bus.s0_odd_page, bus.s0_asid, f, idx, pfn, c, d, v);
      checkOutput({tag, " s0_found"}, 32'(bus.s0_found), 32'(f));
      checkOutput({tag, " s0_index"}, 32'(bus.s0_index), 32'(idx));
      checkOutput({tag, " s0_pfn"},   32'(bus.s0_pfn),   32'(pfn));
      checkOutput({tag, " s0_c"},     32'(bus.s0_c),     32'(c));
      checkOutput({tag, " s0_d"},     32'(bus.s0_d),     32'(d));
      checkOutput({tag, " s0_v"},     32'(bus.s0_v),     32'(v));
      modelSearch(bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid, f, idx, pfn, c, d, v);
      checkOutput({tag, " s1_found"}, 32'(bus.s1_found), 32'(f));
      checkOutput({tag, " s1_index"}, 32'(bus.s1_index), 32'(idx));
      checkOutput({tag, " s1_pfn"},   32'(bus.s1_pfn),   32'(pfn));
      checkOutput({tag, " s1_c"},     32'(bus.s1_c),     32'(c));
      checkOutput({tag, " s1_d"},     32'(bus.s1_d),     32'(d));
      checkOutput({tag, " s1_v"},     32'(bus.s1_v),     32'(v));
   endtask

   task automatic checkRead(input string tag);
      model_entry_t e;
      e = model[bus.r_index];
      checkOutput({tag, " r_vpn2"}, 32'(bus.r_vpn2), 32'(e.vpn2));
      checkOutput({tag, " r_asid"}, 32'(bus.r_asid), 32'(e.asid));
      checkOutput({tag, " r_g"},    32'(bus.r_g),    32'(e.g));
      checkOutput({tag, " r_page0"}, {8'd0, bus.r_pfn0, bus.r_c0, bus.r_d0},
                                     {8'd0, e.pfn[0], e.c[0], e.d[0]});
      checkOutput({tag, " r_page1"}, {8'd0, bus.r_pfn1, bus.r_c1, bus.r_d1},
                                     {8'd0, e.pfn[1], e.c[1], e.d[1]});
      checkOutput({tag, " r_valid"}, 32'({bus.r_v1, bus.r_v0}), 32'({e.v[1], e.v[0]}));
   endtask

   vec_t vecs [6];
   logic [18:0] pool [4];

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 16; i++) model[i] = '0;
      reset = 1'b1;
      bus.we = 1'b0;
      driveWrite(4'd0, '0);
      bus.we = 1'b0;
      bus.r_index = '0;
      bus.s0_vpn2 = '0; bus.s0_odd_page = 1'b0; bus.s0_asid = '0;
      bus.s1_vpn2 = '0; bus.s1_odd_page = 1'b0; bus.s1_asid = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state: zero key with ASID 0 hits entry 0 but reports invalid.
      setKeys(19'h00000, 1'b0, 8'h00, 19'h00000, 1'b1, 8'h05);
      checkOutput("rst s0_found", 32'(bus.s0_found), 32'd1);
      checkOutput("rst s0_index", 32'(bus.s0_index), 32'd0);
      checkOutput("rst s0_v",     32'(bus.s0_v),     32'd0);
      checkOutput("rst s1_found asid5", 32'(bus.s1_found), 32'd0);
      checkRead("rst");

      // Directed vector table around one programmed entry.
      applyStimulus(4'd3, mkEntry(19'h12345, 8'h0A, 1'b0, 20'h00111, 3'd3, 1'b0, 1'b1,
                                  20'h00222, 3'd2, 1'b1, 1'b1));
      vecs[0] = '{19'h12345, 1'b1, 8'h0A, 1'b1, 4'd3, 20'h00222, 1'b1};
      vecs[1] = '{19'h12345, 1'b0, 8'h0A, 1'b1, 4'd3, 20'h00111, 1'b1};
      vecs[2] = '{19'h12345, 1'b1, 8'h0B, 1'b0, 4'd0, 20'h00000, 1'b0};
      vecs[3] = '{19'h00000, 1'b0, 8'h00, 1'b1, 4'd0, 20'h00000, 1'b0};
      vecs[4] = '{19'h00000, 1'b1, 8'h05, 1'b0, 4'd0, 20'h00000, 1'b0};
      vecs[5] = '{19'h12344, 1'b1, 8'h0A, 1'b0, 4'd0, 20'h00000, 1'b0};
      for (int k = 0; k < 6; k++) begin
         setKeys(vecs[k].vpn2, vecs[k].odd, vecs[k].asid, vecs[k].vpn2, vecs[k].odd, vecs[k].asid);
         checkOutput($sformatf("vec%0d s0_found", k), 32'(bus.s0_found), 32'(vecs[k].exp_found));
         checkOutput($sformatf("vec%0d s0_index", k), 32'(bus.s0_index), 32'(vecs[k].exp_index));
         checkOutput($sformatf("vec%0d s0_pfn", k),   32'(bus.s0_pfn),   32'(vecs[k].exp_pfn));
         checkOutput($sformatf("vec%0d s0_v", k),     32'(bus.s0_v),     32'(vecs[k].exp_v));
         checkOutput($sformatf("vec%0d s1_found", k), 32'(bus.s1_found), 32'(vecs[k].exp_found));
         checkOutput($sformatf("vec%0d s1_index", k), 32'(bus.s1_index), 32'(vecs[k].exp_index));
         checkOutput($sformatf("vec%0d s1_pfn", k),   32'(bus.s1_pfn),   32'(vecs[k].exp_pfn));
         checkOutput($sformatf("vec%0d s1_v", k),     32'(bus.s1_v),     32'(vecs[k].exp_v));
      end

      // Global bit: foreign ASID now hits entry 3.
      applyStimulus(4'd3, mkEntry(19'h12345, 8'h0A, 1'b1, 20'h00333, 3'd1, 1'b1, 1'b1,
                                  20'h00444, 3'd5, 1'b0, 1'b0));
      setKeys(19'h12345, 1'b0, 8'h0B, 19'h12345, 1'b1, 8'h0B);
      checkOutput("global s0_index", 32'(bus.s0_index), 32'd3);
      checkOutput("global s0_pfn",   32'(bus.s0_pfn),   32'h00333);
      checkOutput("global s1_pfn",   32'(bus.s1_pfn),   32'h00444);
      checkOutput("global s1_v",     32'(bus.s1_v),     32'd0);

      // Duplicates: lowest index wins.
      applyStimulus(4'd9, mkEntry(19'h2AAAA, 8'h11, 1'b0, 20'h00999, 3'd0, 1'b0, 1'b1,
                                  20'h00998, 3'd0, 1'b0, 1'b1));
      applyStimulus(4'd5, mkEntry(19'h2AAAA, 8'h11, 1'b0, 20'h00555, 3'd4, 1'b1, 1'b1,
                                  20'h00556, 3'd4, 1'b0, 1'b1));
      // Both ports with different hitting keys in one cycle.
      setKeys(19'h12345, 1'b1, 8'h0B, 19'h2AAAA, 1'b0, 8'h11);
      checkOutput("dup s1_index", 32'(bus.s1_index), 32'd5);
      checkOutput("dup s1_pfn",   32'(bus.s1_pfn),   32'h00555);
      checkOutput("dual s0_index", 32'(bus.s0_index), 32'd3);
      checkOutput("dual s0_pfn",   32'(bus.s0_pfn),   32'h00444);
      checkSearches("dual");

      // Same-cycle write and read of entry 7: old data first, new data next cycle.
      driveWrite(4'd7, mkEntry(19'h0BEEF, 8'h22, 1'b0, 20'h00777, 3'd7, 1'b1, 1'b1,
                               20'h00778, 3'd6, 1'b1, 1'b0));
      bus.r_index = 4'd7;
      #1;
      checkOutput("wr/rd old r_vpn2", 32'(bus.r_vpn2), 32'h0);
      checkOutput("wr/rd old r_pfn0", 32'(bus.r_pfn0), 32'h0);
      setKeys(19'h0BEEF, 1'b0, 8'h22, 19'h0BEEF, 1'b1, 8'h22);
      checkOutput("no bypass s0_found", 32'(bus.s0_found), 32'd0);
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      model[7] = mkEntry(19'h0BEEF, 8'h22, 1'b0, 20'h00777, 3'd7, 1'b1, 1'b1,
                         20'h00778, 3'd6, 1'b1, 1'b0);
      checkOutput("wr/rd new r_vpn2", 32'(bus.r_vpn2), 32'h0BEEF);
      checkOutput("wr/rd new r_pfn0", 32'(bus.r_pfn0), 32'h00777);
      checkOutput("wr/rd new s0_index", 32'(bus.s0_index), 32'd7);
      checkRead("wr/rd new");

      // Reset beats a simultaneous write.
      applyStimulus(4'd2, mkEntry(19'h01234, 8'h33, 1'b1, 20'h00AAA, 3'd2, 1'b1, 1'b1,
                                  20'h00BBB, 3'd2, 1'b1, 1'b1));
      bus.r_index = 4'd2;
      #1;
      checkOutput("pre-rst r_vpn2", 32'(bus.r_vpn2), 32'h01234);
      driveWrite(4'd2, mkEntry(19'h05555, 8'h44, 1'b1, 20'h00CCC, 3'd1, 1'b1, 1'b1,
                               20'h00DDD, 3'd1, 1'b1, 1'b1));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.we = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = '0;
      checkOutput("rst+we r_vpn2", 32'(bus.r_vpn2), 32'h0);
      checkOutput("rst+we r_pfn1", 32'(bus.r_pfn1), 32'h0);
      checkOutput("rst+we r_g",    32'(bus.r_g),    32'h0);
      checkRead("rst+we");

      // Randomized phase against the reference model.
      pool[0] = 19'h12345; pool[1] = 19'h2AAAA; pool[2] = 19'h00000; pool[3] = 19'h7FFFF;
      for (int n = 0; n < 300; n++) begin
         logic          doWr;
         logic [3:0]    wIdx;
         model_entry_t  wEnt;
         doWr = ($urandom_range(0, 1) == 1);
         wIdx = 4'($urandom_range(0, 15));
         wEnt = mkEntry(pool[$urandom_range(0, 3)], 8'($urandom_range(0, 3)),
                        ($urandom_range(0, 3) == 0), 20'($urandom), 3'($urandom), 1'($urandom),
                        1'($urandom), 20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
         if (doWr) driveWrite(wIdx, wEnt);
         bus.r_index = 4'($urandom_range(0, 15));
         setKeys(pool[$urandom_range(0, 3)], 1'($urandom), 8'($urandom_range(0, 3)),
                 pool[$urandom_range(0, 3)], 1'($urandom), 8'($urandom_range(0, 3)));
         checkSearches($sformatf("rnd%0d", n));
         checkRead($sformatf("rnd%0d", n));
         @(posedge clk);
         #1;
         bus.we = 1'b0;
         if (doWr) model[wIdx] = wEnt;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
